// File: rtl/lm_sm_pkg.sv
// Shared types and default widths for the LM/SM sequencer.
// Imported by the sequencer and its lowest-set-bit encoder.
package lm_sm_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lm_sm_sequencer_lowest_set_bit_enc.sv
// Combinational priority encoder: index of the lowest set bit.
// vld_o is low when the input vector is all zeros.
module lowest_set_bit_enc #(
  parameter int NUM_REGS = lm_sm_pkg::NUM_REGS,
  parameter int REG_AW   = lm_sm_pkg::REG_AW
) (
  input  logic [NUM_REGS-1:0] vec_i,
  output logic [REG_AW-1:0]   idx_o,
  output logic                vld_o
);

  // Scan downwards so the lowest set bit is the last one assigned.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = REG_AW'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Load/Store-Multiple sequencer: walks a register mask and
// issues one memory transaction per set bit, R0 first.
module lm_sm_sequencer #(
  parameter int DATA_W   = lm_sm_pkg::DATA_W,
  parameter int ADDR_W   = lm_sm_pkg::ADDR_W,
  parameter int NUM_REGS = lm_sm_pkg::NUM_REGS,
  parameter int REG_AW   = lm_sm_pkg::REG_AW
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                is_load,
  input  logic [NUM_REGS-1:0] reg_mask,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic [REG_AW-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]   rf_rdata,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [3:0]          xfer_count
);

  import lm_sm_pkg::*;

  state_e              state_q, state_d;
  logic                ld_q, ld_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [REG_AW-1:0]   cur;
  logic                cur_vld;

  lowest_set_bit_enc #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_enc (
    .vec_i (mask_q),
    .idx_o (cur),
    .vld_o (cur_vld)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ld_q    <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    mask_d    = mask_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_raddr  = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ld_d    = is_load;
          mask_d  = reg_mask;
          addr_d  = base_addr;
          cnt_d   = '0;
          state_d = (reg_mask != '0) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = ~ld_q;
        mem_addr = addr_q;
        rf_raddr = cur;
        if (!ld_q) mem_wdata = rf_rdata;
        if (mem_ack && cur_vld) begin
          if (ld_q) begin
            rf_we    = 1'b1;
            rf_waddr = cur;
            rf_wdata = mem_rdata;
          end
          mask_d[cur] = 1'b0;
          addr_d      = addr_q + ADDR_W'(1);
          cnt_d       = cnt_q + 4'd1;
          state_d     = (mask_d == '0) ? ST_DONE : ST_XFER;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer with memory/RF models.
// Directed plan cases followed by randomized operations.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        is_load;
  logic [7:0]  reg_mask;
  logic [15:0] base_addr;
  logic        busy, done, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [2:0]  rf_raddr, rf_waddr;
  logic [15:0] rf_rdata, rf_wdata;
  logic        rf_we;
  logic [3:0]  xfer_count;

  always #5 clk = ~clk;

  lm_sm_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .is_load    (is_load),
    .reg_mask   (reg_mask),
    .base_addr  (base_addr),
    .busy       (busy),
    .done       (done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .xfer_count (xfer_count)
  );

  typedef struct {
    bit          is_rf;
    logic [15:0] maddr;
    logic [2:0]  rg;
    logic [15:0] data;
  } xact_t;

  typedef struct {
    int cnt;
    int cyc;
  } done_t;

  logic [15:0] dut_mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] dut_rf  [0:7];
  logic [15:0] ref_rf  [0:7];

  xact_t exp_q[$];
  done_t done_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wait_mode = 0;
  bit noise = 0;
  int waited = 0;
  int cur_wait = 0;

  assign rf_rdata = dut_rf[rf_raddr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int pick_wait();
    return (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
  endfunction

  // Memory responder: acks after cur_wait stall cycles.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (waited >= cur_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = dut_mem[mem_addr];
        waited    = 0;
        cur_wait  = pick_wait();
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        waited++;
      end
    end else begin
      mem_ack   = noise ? 1'($urandom) : 1'b0;
      mem_rdata = 16'($urandom);
      waited    = 0;
      cur_wait  = pick_wait();
    end
  end

  // Monitor: pops expectations whenever the DUT shows activity.
  bit          prev_wait = 0;
  logic [15:0] prev_addr, prev_wdata;
  logic        prev_we;

  always @(negedge clk) begin
    xact_t e;
    done_t d;
    if (prev_wait && mem_req && resetn) begin
      chk("hold_addr", mem_addr, prev_addr);
      chk("hold_we", mem_we, prev_we);
      chk("hold_wdata", mem_wdata, prev_wdata);
    end
    prev_wait  = mem_req && !mem_ack;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
    if (!(mem_req && mem_ack)) chk("rf_we_no_ack", rf_we, 0);
    if (mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        chk("xact_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("xact_rf_we", rf_we, e.is_rf);
        chk("xact_mem_we", mem_we, !e.is_rf);
        chk("xact_addr", mem_addr, e.maddr);
        chk("xact_reg", e.is_rf ? rf_waddr : rf_raddr, e.rg);
        chk("xact_data", e.is_rf ? rf_wdata : mem_wdata, e.data);
        if (e.is_rf) ref_rf[e.rg] = e.data;
        else         ref_mem[e.maddr] = e.data;
      end
      if (mem_we) dut_mem[mem_addr] = mem_wdata;
    end
    if (rf_we) dut_rf[rf_waddr] = rf_wdata;
    if (done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", done, 0);
      end else begin
        d = done_q.pop_front();
        chk("done_count", xfer_count, d.cnt);
        chk("done_busy", busy, 1);
        chk("done_pending", exp_q.size(), 0);
        if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
      end
    end
  end

  task automatic issue(input bit ld, input logic [7:0] m,
                       input logic [15:0] b, input int wm);
    xact_t x;
    done_t d;
    int n = 0;
    wait_mode = wm;
    cur_wait  = pick_wait();
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        x.is_rf = ld;
        x.maddr = b + 16'(n);
        x.rg    = 3'(i);
        x.data  = ld ? ref_mem[x.maddr] : ref_rf[i];
        exp_q.push_back(x);
        n++;
      end
    end
    d.cnt = n;
    d.cyc = (wm == 0) ? cyc + n + 1 : -1;
    done_q.push_back(d);
    start     = 1'b1;
    is_load   = ld;
    reg_mask  = m;
    base_addr = b;
  endtask

  task automatic do_op(input bit ld, input logic [7:0] m,
                       input logic [15:0] b, input int wm,
                       input bit junk);
    int k;
    issue(ld, m, b, wm);
    @(posedge clk); #1;
    start     = junk;
    is_load   = 1'($urandom);
    reg_mask  = 8'($urandom);
    base_addr = 16'($urandom);
    for (k = 0; k < 400; k++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    if (k >= 400) chk("done_timeout", k, 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    is_load   = 1'b0;
    reg_mask  = '0;
    base_addr = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 65536; i++) begin
      dut_mem[i] = 16'($urandom);
      ref_mem[i] = dut_mem[i];
    end
    for (int i = 0; i < 8; i++) begin
      dut_rf[i] = 16'($urandom);
      ref_rf[i] = dut_rf[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_count", xfer_count, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    do_op(1'b1, 8'h05, 16'h0100, 0, 1'b0);
    chk("lm05_count", xfer_count, 2);

    dut_rf[0] = 16'hAAAA; ref_rf[0] = 16'hAAAA;
    dut_rf[7] = 16'h5555; ref_rf[7] = 16'h5555;
    do_op(1'b0, 8'h81, 16'h0200, 0, 1'b1);
    chk("sm_mem200", dut_mem[16'h0200], 16'hAAAA);
    chk("sm_mem201", dut_mem[16'h0201], 16'h5555);

    issue(1'b1, 8'h00, 16'h1234, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("m0_busy1", busy, 1);
    chk("m0_done1", done, 1);
    chk("m0_req1", mem_req, 0);
    @(posedge clk); #1;
    chk("m0_busy2", busy, 0);
    chk("m0_done2", done, 0);

    do_op(1'b1, 8'hFF, 16'hFFFE, 2, 1'b0);
    chk("ff_count", xfer_count, 8);
    chk("ff_r2", dut_rf[2], ref_mem[16'h0000]);

    // Abort: LM 0x0F, ignored restart in cycle 2, reset in cycle 3.
    noise = 1'b1;
    issue(1'b1, 8'h0F, 16'h3000, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start    = 1'b1;
    reg_mask = 8'hF0;
    @(posedge clk); #1;
    start  = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("ab_busy", busy, 0);
    chk("ab_req", mem_req, 0);
    chk("ab_rf_we", rf_we, 0);
    chk("ab_addr", mem_addr, 0);
    chk("ab_count", xfer_count, 0);
    chk("ab_left", exp_q.size(), 1);
    exp_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    chk("ab_done", done, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    do_op(1'b1, 8'h0F, 16'h3100, 0, 1'b0);
    chk("ab_rerun_count", xfer_count, 4);

    for (int n = 0; n < 40; n++) begin
      logic [7:0]  m;
      logic [15:0] b;
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                      : 16'($urandom);
      noise = 1'($urandom);
      do_op(1'($urandom), m, b, int'($urandom_range(0, 3)) - 1,
            1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("end_exp_q", exp_q.size(), 0);
    chk("end_done_q", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Multi-cycle sequencer for Load-Multiple (LM) and Store-Multiple (SM) instructions.
- Walks an 8-bit register mask and issues one memory transaction per set bit.
- Drives the register file write port for LM and the read port for SM.
- Sits between the decode/execute control FSM and the 8x16-bit register file plus data memory. Owns both resources while busy.

Parameters:
- DATA_W, 16, register and memory data width.
- ADDR_W, 16, memory word-address width.
- NUM_REGS, 8, number of architectural registers; mask width.
- REG_AW, 3, register index width (log2 NUM_REGS).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- is_load  in  1  1 = LM (mem->reg), 0 = SM (reg->mem); latched at start.
- reg_mask  in  NUM_REGS  bit i set = transfer register Ri; latched at start.
- base_addr  in  ADDR_W  first memory word address; latched at start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write (SM); valid while mem_req.
- mem_addr  out  ADDR_W  current word address.
- mem_wdata  out  DATA_W  equals rf_rdata during SM requests.
- mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.
- mem_ack  in  1  transaction complete this cycle.
- rf_raddr  out  REG_AW  register read index (SM).
- rf_rdata  in  DATA_W  combinational read data for rf_raddr.
- rf_we  out  1  register write enable (LM).
- rf_waddr  out  REG_AW  register write index.
- rf_wdata  out  DATA_W  register write data (equals mem_rdata).
- xfer_count  out  4  transfers completed in the current operation.

Behaviour:
- States: IDLE, XFER, DONE.
- Reset (resetn=0 at a rising edge):
  - State goes to IDLE; latched mask, address and xfer_count clear to 0.
  - All outputs are 0: busy, done, mem_req, mem_we, rf_we, all addresses and data.
  - Reset mid-operation aborts immediately. mem_req drops at that edge, no further rf_we, and no done pulse.
- IDLE:
  - On start=1: latch is_load, reg_mask and base_addr; clear xfer_count.
  - Next state is XFER if reg_mask != 0, else DONE.
- XFER:
  - Current register cur = lowest set bit of the remaining mask.
  - Transfer order is ascending: R0 first, R7 last.
  - mem_req=1, mem_we=~is_load, mem_addr=current address.
  - rf_raddr=cur, mem_wdata=rf_rdata.
  - Wait cycles: if mem_ack=0, hold all request outputs stable and change no state.
  - mem_ack=1 with LM: rf_we=1, rf_waddr=cur, rf_wdata=mem_rdata, all combinationally in the ack cycle. The register file captures at that edge.
  - mem_ack=1 with SM: rf_we stays 0.
  - On ack at the edge: clear bit cur, address +1 (mod 2^ADDR_W, 0xFFFF wraps to 0x0000), xfer_count +1.
  - If the remaining mask becomes 0, go to DONE. Otherwise stay in XFER with no idle cycle (back-to-back requests).
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- start while busy is ignored, including in the DONE cycle.
- start in IDLE one cycle after DONE is accepted.
- Inputs reg_mask, base_addr and is_load may change freely after start.
- Latency with a zero-wait memory:
  - N set bits: done is asserted in cycle N+1 after the start edge.
  - Mask 0: done is asserted in cycle 1 with no memory or register-file activity.
- mem_ack outside XFER is ignored.
- xfer_count holds its final value after DONE until the next accepted start or reset.

Decomposition:
- Package lm_sm_pkg:
  - State enum constants ST_IDLE, ST_XFER, ST_DONE (2-bit).
  - Defaults for DATA_W, ADDR_W, NUM_REGS, REG_AW.
- Sub-module lowest_set_bit_enc: combinational, NUM_REGS-bit vector in, REG_AW index plus valid out. The sequencer instantiates it once on the remaining mask.

Test Plan:
- LM, mask=0x05, base=0x0100, ack every cycle:
  - reads 0x0100->R0, then 0x0101->R2.
  - rf_we pulses in cycles 1 and 2.
  - done in cycle 3; xfer_count=2.
- SM, mask=0x81, base=0x0200, R0=0xAAAA, R7=0x5555:
  - writes mem[0x0200]=0xAAAA, then mem[0x0201]=0x5555.
  - rf_we stays 0 throughout.
- Mask=0x00:
  - no mem_req and no rf_we.
  - busy and done high in cycle 1 only; back to IDLE in cycle 2.
- LM, mask=0xFF, base=0xFFFE, mem_ack delayed 2 cycles per transaction:
  - request outputs stay stable during the wait cycles.
  - addresses issued are 0xFFFE, 0xFFFF, 0x0000 ... 0x0005.
  - 8 writes to R0..R7 in order.
- Mid-operation events, LM mask=0x0F:
  - a second start in cycle 2 is ignored.
  - resetn=0 in cycle 3 gives all outputs 0 at the next edge.
  - no done pulse; xfer_count=0.
  - a new start after release runs cleanly.
